// File: rtl/key_scan.sv
// 4x4 matrix-keypad scanner: walks an active-low column strobe, debounces the
// synchronized rows and reports one event per accepted press.
module key_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_TICKS + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_TICKS);

  localparam logic [1:0] S_SCAN      = 2'd0;
  localparam logic [1:0] S_DEB_PRESS = 2'd1;
  localparam logic [1:0] S_HELD      = 2'd2;
  localparam logic [1:0] S_DEB_REL   = 2'd3;

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [DW-1:0] r_div;
  logic [CW-1:0] r_deb_cnt;
  logic [1:0]    r_state;
  logic [1:0]    r_col_idx;
  logic [3:0]    r_cand;
  logic [3:0]    r_code;
  logic          r_valid;
  logic          r_down;

  logic          w_tick;
  logic          w_hit;
  logic [1:0]    w_row_idx;
  logic [CW-1:0] w_deb_nxt;

  assign w_tick    = (r_div == DIV_MAX);
  assign w_hit     = ~&r_sync2;
  assign w_deb_nxt = r_deb_cnt + CW'(1);

  // Row 0 wins when several rows are pulled low at once.
  always_comb begin
    w_row_idx = 2'd3;
    if (!r_sync2[0])      w_row_idx = 2'd0;
    else if (!r_sync2[1]) w_row_idx = 2'd1;
    else if (!r_sync2[2]) w_row_idx = 2'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 4'b1111;
      r_sync2   <= 4'b1111;
      r_div     <= '0;
      r_deb_cnt <= '0;
      r_state   <= S_SCAN;
      r_col_idx <= 2'd0;
      r_cand    <= 4'd0;
      r_code    <= 4'd0;
      r_valid   <= 1'b0;
      r_down    <= 1'b0;
    end else begin
      r_sync1 <= key_row;
      r_sync2 <= r_sync1;
      r_div   <= w_tick ? '0 : r_div + DW'(1);
      r_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_SCAN: begin
            if (w_hit) begin
              r_cand <= {r_col_idx, w_row_idx};
              if (DEB_TICKS == 1) begin
                r_code  <= {r_col_idx, w_row_idx};
                r_valid <= 1'b1;
                r_down  <= 1'b1;
                r_state <= S_HELD;
              end else begin
                r_deb_cnt <= CW'(1);
                r_state   <= S_DEB_PRESS;
              end
            end else begin
              r_col_idx <= r_col_idx + 2'd1;
            end
          end
          S_DEB_PRESS: begin
            if (w_hit && (w_row_idx == r_cand[1:0])) begin
              r_deb_cnt <= w_deb_nxt;
              if (w_deb_nxt == DEB_MAX) begin
                r_code  <= r_cand;
                r_valid <= 1'b1;
                r_down  <= 1'b1;
                r_state <= S_HELD;
              end
            end else begin
              // Bounce: resume scanning from the same column next tick.
              r_deb_cnt <= '0;
              r_state   <= S_SCAN;
            end
          end
          S_HELD: begin
            if (!w_hit) begin
              if (DEB_TICKS == 1) begin
                r_down    <= 1'b0;
                r_state   <= S_SCAN;
                r_col_idx <= r_col_idx + 2'd1;
              end else begin
                r_deb_cnt <= CW'(1);
                r_state   <= S_DEB_REL;
              end
            end
          end
          S_DEB_REL: begin
            if (!w_hit) begin
              r_deb_cnt <= w_deb_nxt;
              if (w_deb_nxt == DEB_MAX) begin
                r_down    <= 1'b0;
                r_state   <= S_SCAN;
                r_col_idx <= r_col_idx + 2'd1;
              end
            end else begin
              r_state <= S_HELD;
            end
          end
          default: r_state <= S_SCAN;
        endcase
      end
    end
  end

  assign key_col   = ~(4'b0001 << r_col_idx);
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_down  = r_down;

endmodule
